// File: rtl/down_count_monitor.sv
// down_count_monitor
//   Consumer-side checker for a WIDTH-bit down counter stream. Every valid sample is
//   compared with the previous one: a legal step is prev-1 (mod 2^WIDTH). The monitor
//   acquires lock after LOCK_SAMPLES consecutive legal steps, counts legal 0 -> max wraps
//   and flags illegal steps seen while locked. All outputs are registered.
//
// Configuration macro:
//   DCM_HOLD_ALLOW_EN - when defined, a repeated value (upstream stall) is neutral instead
//                       of an illegal step.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset, overrides all other inputs
//   q_in       in   count value from upstream counter
//   q_valid    in   q_in is sampled on this edge when high
//   locked     out  monitor is tracking the sequence
//   wrap_pulse out  one-cycle pulse on a legal 0 -> max step
//   wrap_count out  saturating count of legal wraps
//   err_pulse  out  one-cycle pulse on an illegal step while locked
//   err_sticky out  set by err_pulse, cleared only by reset
//   last_q     out  last sampled q_in
module down_count_monitor #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned WRAP_CNT_W   = 8,
  parameter int unsigned LOCK_SAMPLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      q_in,
  input  logic                  q_valid,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [WIDTH-1:0]      last_q
);

  localparam int unsigned GoodW = $clog2(LOCK_SAMPLES + 1);

  typedef enum logic [1:0] {StIdle, StAcquire, StTrack} state_e;

  state_e                  state_q, state_d;
  logic [GoodW-1:0]        good_cnt_q, good_cnt_d, good_inc;
  logic                    locked_d, wrap_d, err_d, sticky_d;
  logic [WRAP_CNT_W-1:0]   wrap_count_d;
  logic [WIDTH-1:0]        last_d;
  logic                    legal_step, wrap_step, hold_neutral;

  // Wrap-around subtraction: operands are WIDTH bits, so 0 - 1 yields all-ones.
  assign legal_step = (q_in == last_q - WIDTH'(1));
  assign wrap_step  = legal_step && (last_q == '0) && (q_in == '1);
  assign good_inc   = good_cnt_q + GoodW'(1);

`ifdef DCM_HOLD_ALLOW_EN
  // A stalled upstream repeats its value; treat that as "no new information".
  assign hold_neutral = (q_in == last_q);
`else
  assign hold_neutral = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    last_d       = last_q;
    wrap_d       = 1'b0;
    err_d        = 1'b0;
    wrap_count_d = wrap_count;

    if (q_valid) begin
      last_d = q_in;
      unique case (state_q)
        StIdle: begin
          // First sample has no predecessor, so no step check.
          state_d    = StAcquire;
          good_cnt_d = '0;
        end
        StAcquire: begin
          if (legal_step) begin
            good_cnt_d = good_inc;
            if (good_inc == GoodW'(LOCK_SAMPLES)) begin
              state_d = StTrack;
            end
          end else if (!hold_neutral) begin
            good_cnt_d = '0;
          end
        end
        StTrack: begin
          if (!legal_step && !hold_neutral) begin
            err_d      = 1'b1;
            state_d    = StAcquire;
            good_cnt_d = '0;
          end
        end
        default: state_d = StIdle;
      endcase

      if (wrap_step && (state_q != StIdle)) begin
        wrap_d = 1'b1;
        if (wrap_count != '1) begin
          wrap_count_d = wrap_count + WRAP_CNT_W'(1);
        end
      end
    end

    locked_d = (state_d == StTrack);
    sticky_d = err_sticky | err_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      good_cnt_q <= '0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      locked     <= locked_d;
      wrap_pulse <= wrap_d;
      wrap_count <= wrap_count_d;
      err_pulse  <= err_d;
      err_sticky <= sticky_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// Bench for down_count_monitor: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a run-length reference model.
module tb_down_count_monitor;

  localparam int Lock = 2;
`ifdef DCM_HOLD_ALLOW_EN
  localparam bit HoldAllow = 1'b1;
`else
  localparam bit HoldAllow = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       q_valid = 1'b0;
  logic [3:0] q_in = 4'd0;

  logic       locked, wrap_pulse, err_pulse, err_sticky;
  logic [7:0] wrap_count;
  logic [3:0] last_q;
  logic       locked2, wrap_pulse2, err_pulse2, err_sticky2;
  logic [1:0] wrap_count2;
  logic [3:0] last_q2;

  down_count_monitor #(.WIDTH(4), .WRAP_CNT_W(8), .LOCK_SAMPLES(Lock)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
    .locked(locked), .wrap_pulse(wrap_pulse), .wrap_count(wrap_count),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .last_q(last_q)
  );

  down_count_monitor #(.WIDTH(4), .WRAP_CNT_W(2), .LOCK_SAMPLES(Lock)) dut2 (
    .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid),
    .locked(locked2), .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2),
    .err_pulse(err_pulse2), .err_sticky(err_sticky2), .last_q(last_q2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  // Reference model: m_run = consecutive legal steps since the last break (capped at Lock).
  int m_last, m_run, m_wc, m_wc2;
  bit m_have, m_locked, m_wrap, m_err, m_sticky;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_last = 0; m_run = 0; m_wc = 0; m_wc2 = 0;
      m_have = 0; m_locked = 0; m_wrap = 0; m_err = 0; m_sticky = 0;
    end else begin
      m_wrap = 0;
      m_err  = 0;
      if (q_valid) begin
        if (!m_have) begin
          m_have = 1;
          m_run  = 0;
        end else if (int'(q_in) == (m_last + 15) % 16) begin
          if (m_last == 0) begin
            m_wrap = 1;
            if (m_wc < 255) m_wc++;
            if (m_wc2 < 3) m_wc2++;
          end
          if (m_run < Lock) m_run++;
        end else if (HoldAllow && int'(q_in) == m_last) begin
          m_run = m_run;
        end else begin
          if (m_run >= Lock) begin
            m_err    = 1;
            m_sticky = 1;
          end
          m_run = 0;
        end
        m_last = int'(q_in);
      end
      m_locked = (m_run >= Lock);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (en) begin
      chk("locked", 32'(locked), 32'(m_locked));
      chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
      chk("wrap_count", 32'(wrap_count), 32'(m_wc));
      chk("err_pulse", 32'(err_pulse), 32'(m_err));
      chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
      chk("last_q", 32'(last_q), 32'(m_last));
      chk("locked2", 32'(locked2), 32'(m_locked));
      chk("wrap_pulse2", 32'(wrap_pulse2), 32'(m_wrap));
      chk("wrap_count2", 32'(wrap_count2), 32'(m_wc2));
      chk("err_pulse2", 32'(err_pulse2), 32'(m_err));
      chk("err_sticky2", 32'(err_sticky2), 32'(m_sticky));
      chk("last_q2", 32'(last_q2), 32'(m_last));
    end
  end

  task automatic cyc(input bit r, input bit v, input logic [3:0] q);
    reset   = r;
    q_valid = v;
    q_in    = q;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n_wrap;
    int drv_last;
    int k;
    bit rst, v;
    logic [3:0] q;

    cyc(1, 0, 4'd0);
    en = 1'b1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_wrap_count", 32'(wrap_count), 0);
    chk("rst_err_sticky", 32'(err_sticky), 0);
    chk("rst_last_q", 32'(last_q), 0);

    // Lock on 15,14,13.
    cyc(0, 1, 4'd15);
    cyc(0, 1, 4'd14);
    chk("t1_not_yet_locked", 32'(locked), 0);
    cyc(0, 1, 4'd13);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_sticky", 32'(err_sticky), 0);

    // Run down to 0 and wrap to 15.
    for (int i = 12; i >= 0; i--) cyc(0, 1, 4'(i));
    chk("t2_no_wrap_yet", 32'(wrap_pulse), 0);
    cyc(0, 1, 4'd15);
    chk("t2_wrap_pulse", 32'(wrap_pulse), 1);
    chk("t2_wrap_count", 32'(wrap_count), 1);
    cyc(0, 0, 4'd0);
    chk("t2_wrap_pulse_gone", 32'(wrap_pulse), 0);

    // Locked at 9, then skip to 7.
    for (int i = 14; i >= 9; i--) cyc(0, 1, 4'(i));
    cyc(0, 1, 4'd7);
    chk("t3_err_pulse", 32'(err_pulse), 1);
    chk("t3_err_sticky", 32'(err_sticky), 1);
    chk("t3_unlocked", 32'(locked), 0);
    cyc(0, 1, 4'd6);
    chk("t3_err_pulse_gone", 32'(err_pulse), 0);
    cyc(0, 1, 4'd5);
    chk("t3_relocked", 32'(locked), 1);
    chk("t3_sticky_held", 32'(err_sticky), 1);

    // Repeated value while locked.
    cyc(0, 1, 4'd5);
    chk("t5_err_pulse", 32'(err_pulse), HoldAllow ? 0 : 1);
    chk("t5_locked", 32'(locked), HoldAllow ? 1 : 0);
    cyc(0, 1, 4'd4);
    chk("t5_locked_after_4", 32'(locked), HoldAllow ? 1 : 0);

    // Two more wraps, then reset together with a valid sample.
    for (int i = 3; i >= 0; i--) cyc(0, 1, 4'(i));
    for (int i = 15; i >= 0; i--) cyc(0, 1, 4'(i));
    cyc(0, 1, 4'd15);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_wrap_count", 32'(wrap_count), 3);
    chk("t4_sticky", 32'(err_sticky), 1);
    cyc(1, 1, 4'd14);
    chk("t4_locked_rst", 32'(locked), 0);
    chk("t4_wrap_count_rst", 32'(wrap_count), 0);
    chk("t4_sticky_rst", 32'(err_sticky), 0);
    chk("t4_last_q_rst", 32'(last_q), 0);
    chk("t4_err_pulse_rst", 32'(err_pulse), 0);

    // Five continuous 15..0 passes: four wraps, 2-bit counter saturates at 3.
    n_wrap = 0;
    for (int c = 0; c < 5; c++) begin
      for (int i = 15; i >= 0; i--) begin
        cyc(0, 1, 4'(i));
        if (wrap_pulse2) n_wrap++;
      end
    end
    chk("t6_wrap_pulses", 32'(n_wrap), 4);
    chk("t6_wrap_count2", 32'(wrap_count2), 3);
    chk("t6_wrap_count8", 32'(wrap_count), 4);

    // Randomized: mostly legal steps, some holds, jumps, idle cycles and resets.
    drv_last = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      v   = ($urandom_range(0, 3) != 0);
      k   = int'($urandom_range(0, 19));
      if (k < 15)      q = 4'((drv_last + 15) % 16);
      else if (k < 17) q = 4'(drv_last);
      else             q = 4'($urandom_range(0, 15));
      cyc(rst, v, q);
      if (rst) drv_last = 0;
      else if (v) drv_last = int'(q);
    end

    // Long legal run without reset to push the 8-bit counter into saturation.
    for (int i = 0; i < 6000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      q = 4'((drv_last + 15) % 16);
      cyc(0, v, q);
      if (v) drv_last = int'(q);
    end
    chk("sat_wrap_count8", 32'(wrap_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
